// File: rtl/median_driver_pkg.sv
// Shared types and defaults for the median core stream front-end.
package median_pkg;

  typedef logic [7:0] sample_t;

  typedef enum logic [2:0] {
    LOAD,
    ARM,
    SEND,
    WAIT,
    HOLD
  } median_drv_state_t;

  localparam int MEDIAN_N_SAMPLES   = 9;
  localparam int MEDIAN_DRV_TIMEOUT = 64;

endpackage

// File: rtl/median_driver_if.sv
// Bus bundle for median_driver: upstream stream, median core burst port, downstream result.
interface median_driver_if;
  import median_pkg::*;

  // Upstream (in_*) and downstream (res_*) are valid/ready: a transfer happens on a
  // rising edge where valid and ready are both 1; valid, once raised, holds its data
  // stable until that edge. DI/DSI/DO/DSO follow the core's strobe timing instead.
  sample_t in_data;
  logic    in_valid;
  logic    in_ready;
  sample_t DI;
  logic    DSI;
  sample_t DO;
  logic    DSO;
  sample_t res_data;
  logic    res_valid;
  logic    res_ready;

  modport master (
    input  in_data, in_valid, DO, DSO, res_ready,
    output in_ready, DI, DSI, res_data, res_valid
  );

  modport slave (
    output in_data, in_valid, DO, DSO, res_ready,
    input  in_ready, DI, DSI, res_data, res_valid
  );

endinterface

// File: rtl/median_drv_buf.sv
// Sample window storage: one write port, one asynchronous read port, no reset on data.
module median_drv_buf
  import median_pkg::*;
#(
  parameter int N_SAMPLES = MEDIAN_N_SAMPLES,
  localparam int CW = $clog2(N_SAMPLES + 1)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [CW-1:0] waddr,
  input  sample_t       wdata,
  input  logic [CW-1:0] raddr,
  output sample_t       rdata
);

  sample_t mem [N_SAMPLES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/median_driver.sv
// Buffers N_SAMPLES pixels, replays them as one DSI burst, returns the core's median.
// Optional WAIT watchdog with err flag: define MEDIAN_DRIVER_TIMEOUT_EN.
module median_driver
  import median_pkg::*;
#(
  parameter int N_SAMPLES = MEDIAN_N_SAMPLES,
  parameter int TIMEOUT   = MEDIAN_DRV_TIMEOUT
) (
  input  logic              CLK,
  input  logic              nRST,
  median_driver_if.master   bus,
  output logic              err,
  output median_drv_state_t state_dbg
);

  localparam int            CW   = $clog2(N_SAMPLES + 1);
  localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);
  localparam logic [CW-1:0] NS   = CW'(N_SAMPLES);

  median_drv_state_t state, state_next;
  logic [CW-1:0]     wcnt, wcnt_next, rcnt, rcnt_next;
  sample_t           di_q, di_next, res_q, res_next, rd_data;
  logic              dsi_q, dsi_next, rv_q, rv_next, wr_en;

`ifdef MEDIAN_DRIVER_TIMEOUT_EN
  localparam int            WW    = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);
  logic [WW-1:0] wdog, wdog_next;
  logic          err_q, err_next;
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  median_drv_buf #(.N_SAMPLES(N_SAMPLES)) u_buf (
    .clk   (CLK),
    .we    (wr_en),
    .waddr (wcnt),
    .wdata (bus.in_data),
    .raddr (rcnt),
    .rdata (rd_data)
  );

  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    rcnt_next  = rcnt;
    di_next    = '0;
    dsi_next   = 1'b0;
    res_next   = res_q;
    rv_next    = rv_q;
    wr_en      = 1'b0;
`ifdef MEDIAN_DRIVER_TIMEOUT_EN
    err_next   = err_q;
    wdog_next  = '0;
`endif
    case (state)
      LOAD: begin
        if (bus.in_valid) begin
          wr_en = 1'b1;
          if (wcnt == LAST) begin
            wcnt_next  = '0;
            state_next = ARM;
          end else begin
            wcnt_next = wcnt + 1'b1;
          end
        end
      end
      ARM: begin
        // A strobe still held from the previous result must drop before a new burst.
        if (!bus.DSO) begin
          state_next = SEND;
          dsi_next   = 1'b1;
          di_next    = rd_data;
          rcnt_next  = rcnt + 1'b1;
        end
      end
      SEND: begin
        if (rcnt == NS) begin
          state_next = WAIT;
          rcnt_next  = '0;
        end else begin
          dsi_next  = 1'b1;
          di_next   = rd_data;
          rcnt_next = rcnt + 1'b1;
        end
      end
      WAIT: begin
        if (bus.DSO) begin
          res_next   = bus.DO;
          rv_next    = 1'b1;
          state_next = HOLD;
        end
`ifdef MEDIAN_DRIVER_TIMEOUT_EN
        else if (wdog == WLAST) begin
          state_next = LOAD;
          err_next   = 1'b1;
        end else begin
          wdog_next = wdog + 1'b1;
        end
`endif
      end
      HOLD: begin
        if (bus.res_ready) begin
          rv_next    = 1'b0;
          state_next = LOAD;
`ifdef MEDIAN_DRIVER_TIMEOUT_EN
          err_next   = 1'b0;
`endif
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= LOAD;
      wcnt  <= '0;
      rcnt  <= '0;
      di_q  <= '0;
      dsi_q <= 1'b0;
      res_q <= '0;
      rv_q  <= 1'b0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
      rcnt  <= rcnt_next;
      di_q  <= di_next;
      dsi_q <= dsi_next;
      res_q <= res_next;
      rv_q  <= rv_next;
    end
  end

`ifdef MEDIAN_DRIVER_TIMEOUT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      wdog  <= wdog_next;
      err_q <= err_next;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bus.in_ready  = (state == LOAD);
  assign bus.DI        = di_q;
  assign bus.DSI       = dsi_q;
  assign bus.res_data  = res_q;
  assign bus.res_valid = rv_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_median_driver.sv
// Directed bench for median_driver: bursts, backpressure, held DSO, reset mid-SEND, timeout.
`timescale 1ns/1ps
module tb_median_driver;
  import median_pkg::*;

  logic              CLK;
  logic              nRST;
  logic              err;
  median_drv_state_t state_dbg;
  median_driver_if   bus ();

  int tests = 0;
  int fails = 0;

  logic [7:0] v1 [9] = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6, 8'd4};
  logic [7:0] v2 [9] = '{8'd20, 8'd80, 8'd40, 8'd10, 8'd90, 8'd30, 8'd70, 8'd50, 8'd60};
  logic [7:0] v3 [9] = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd14, 8'd16, 8'd18};
  logic [7:0] v4 [9] = '{8'd108, 8'd100, 8'd107, 8'd101, 8'd104, 8'd106, 8'd102, 8'd105, 8'd103};
  logic [7:0] v5 [9] = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88, 8'd99};
  logic [7:0] v6 [9] = '{8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd90, 8'd80, 8'd70, 8'd60};

  median_driver #(.N_SAMPLES(9), .TIMEOUT(16)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .bus       (bus),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic feed(input logic [7:0] s [9], input bit bursty);
    for (int i = 0; i < 9; i++) begin
      if (bursty) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          bus.in_data  = 8'hFF;
          @(negedge CLK);
        end
      end
      bus.in_data  = s[i];
      bus.in_valid = 1'b1;
      check("in_ready_load", bus.in_ready, 1);
      @(negedge CLK);
    end
    bus.in_data = 8'hAA;
    check("in_ready_drop", bus.in_ready, 0);
  endtask

  task automatic wait_dsi();
    int n = 0;
    while (!bus.DSI && n < 30) begin
      @(negedge CLK);
      n++;
    end
    check("dsi_start", bus.DSI, 1);
  endtask

  task automatic check_burst(input logic [7:0] s [9]);
    wait_dsi();
    for (int i = 0; i < 9; i++) begin
      check("burst_dsi", bus.DSI, 1);
      check("burst_di", bus.DI, s[i]);
      @(negedge CLK);
    end
    check("burst_end_dsi", bus.DSI, 0);
    check("burst_end_di", bus.DI, 0);
  endtask

  task automatic result_pulse(input logic [7:0] v, input bit hold);
    @(negedge CLK);
    bus.DSO = 1'b1;
    bus.DO  = v;
    @(negedge CLK);
    if (!hold) begin
      bus.DSO = 1'b0;
      bus.DO  = 8'h00;
    end
    check("res_valid_set", bus.res_valid, 1);
    check("res_data", bus.res_data, v);
  endtask

  task automatic handshake();
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge CLK);
    bus.res_ready = 1'b0;
    check("res_valid_clr", bus.res_valid, 0);
    check("in_ready_after_hs", bus.in_ready, 1);
  endtask

  initial begin
    nRST          = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.DO        = 8'h00;
    bus.DSO       = 1'b0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_di", bus.DI, 0);
    check("rst_dsi", bus.DSI, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_state", state_dbg, LOAD);
    nRST = 1'b1;
    @(negedge CLK);

    // basic burst, in_valid held high
    feed(v1, 1'b0);
    check_burst(v1);
    result_pulse(8'd5, 1'b0);
    check("basic_err", err, 0);
    handshake();

    // bursty upstream, result held under backpressure
    feed(v2, 1'b1);
    check_burst(v2);
    result_pulse(8'd50, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("hold_valid", bus.res_valid, 1);
      check("hold_data", bus.res_data, 50);
      check("hold_in_ready", bus.in_ready, 0);
    end
    handshake();

    // level-held DSO across the next load
    feed(v3, 1'b0);
    check_burst(v3);
    result_pulse(8'd10, 1'b1);
    handshake();
    check("held_dso_no_recapture", bus.res_valid, 0);
    feed(v4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("arm_stall_dsi", bus.DSI, 0);
      check("arm_stall_state", state_dbg, ARM);
      check("arm_stall_rv", bus.res_valid, 0);
      @(negedge CLK);
    end
    bus.DSO = 1'b0;
    bus.DO  = 8'h00;
    check_burst(v4);
    result_pulse(8'd104, 1'b0);
    handshake();

    // reset during the 4th DSI cycle
    feed(v5, 1'b0);
    wait_dsi();
    bus.in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check("mid_send_dsi", bus.DSI, 1);
    check("mid_send_di", bus.DI, 44);
    nRST = 1'b0;
    #1;
    check("async_rst_dsi", bus.DSI, 0);
    check("async_rst_state", state_dbg, LOAD);
    @(negedge CLK);
    check("rst_send_dsi", bus.DSI, 0);
    check("rst_send_di", bus.DI, 0);
    check("rst_send_rv", bus.res_valid, 0);
    nRST = 1'b1;
    check("rst_send_in_ready", bus.in_ready, 1);
    @(negedge CLK);
    feed(v6, 1'b0);
    check_burst(v6);
    result_pulse(8'd50, 1'b0);
    handshake();

    // core never answers
    feed(v1, 1'b0);
    check_burst(v1);
    bus.in_valid = 1'b0;
`ifdef MEDIAN_DRIVER_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      @(negedge CLK);
      check("wdog_err_low", err, 0);
      check("wdog_in_ready_low", bus.in_ready, 0);
    end
    @(negedge CLK);
    check("timeout_err", err, 1);
    check("timeout_in_ready", bus.in_ready, 1);
    check("timeout_rv", bus.res_valid, 0);
    feed(v2, 1'b0);
    check_burst(v2);
    result_pulse(8'd50, 1'b0);
    check("err_kept_until_hs", err, 1);
    handshake();
    check("err_cleared", err, 0);
`else
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      check("no_wdog_err", err, 0);
      check("no_wdog_in_ready", bus.in_ready, 0);
      check("no_wdog_state", state_dbg, WAIT);
    end
`endif

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/median_driver.md
# median_driver

Stream front-end for the median core. Collects `N_SAMPLES` 8-bit pixels from an upstream valid/ready source into a local buffer. Replays them as one contiguous `DSI`-qualified burst on the core's `DI` input, then captures the core's `DO` result when `DSO` rises. Presents the median to downstream on a valid/ready port, so a pixel-window generator can drive the median core without matching its strict burst timing.

## Interface
- `N_SAMPLES`, default 9: samples per burst; 2..15.
- `TIMEOUT`, default 64: max cycles in WAIT before abort; only used with the timeout macro.
- `CLK` input 1: single clock, rising edge.
- `nRST` input 1: reset, asynchronous, active-low.
- `in_data` input 8: upstream sample.
- `in_valid` input 1: upstream sample valid.
- `in_ready` output 1: block accepts a sample this cycle.
- `DI` output 8: sample to the median core, registered.
- `DSI` output 1: burst qualifier to the median core, registered.
- `DO` input 8: median result from the core.
- `DSO` input 1: result strobe from the core.
- `res_data` output 8: captured median, registered.
- `res_valid` output 1: `res_data` valid.
- `res_ready` input 1: downstream accepts the result.
- `err` output 1: timeout abort flag. Tied 0 without the macro.

## Operation
- FSM states: LOAD, ARM, SEND, WAIT, HOLD. Reset state is LOAD.
- **LOAD**
  - `in_ready`=1.
  - Each `in_valid && in_ready` writes `in_data` to `buf[wcnt]` and increments `wcnt`.
  - When the sample at `wcnt`=`N_SAMPLES`-1 is accepted, go to ARM and clear `wcnt`.
- **ARM**
  - `in_ready`=0.
  - Stay while `DSO`=1, so a level-held strobe from the previous result is not recaptured.
  - Go to SEND when `DSO`=0.
- **SEND**
  - Drive `DSI`=1 and `DI`=`buf[rcnt]` for exactly `N_SAMPLES` consecutive cycles, `rcnt` 0..`N_SAMPLES`-1.
  - No gaps; `DSI` never drops mid-burst.
  - After the last sample go to WAIT, with `DSI`=0 and `DI`=0.
- **WAIT**
  - On the first cycle with `DSO`=1, register `DO` into `res_data`, set `res_valid`=1, and go to HOLD.
- **HOLD**
  - `res_valid` stays 1 and `res_data` stays stable until `res_ready`=1.
  - On the handshake: `res_valid`=0 next cycle, go to LOAD.
  - `DSO` is ignored.
- Upstream backpressure:
  - `in_ready`=0 in every state except LOAD.
  - Samples offered outside LOAD are not consumed.
- Counters `wcnt`/`rcnt` are `$clog2(N_SAMPLES+1)` bits wide and saturate/clear explicitly; there is no modular wrap.
- Reset mid-operation:
  - All state clears immediately: FSM to LOAD, counters 0, and a partial buffer is discarded.
  - `DSI`=0, `DI`=0, `res_valid`=0, `res_data`=0, `err`=0.

## Timing
- Reset values:
  - `DI`=0, `DSI`=0, `res_data`=0, `res_valid`=0, `err`=0.
  - `in_ready`=1, decoded combinationally from state LOAD.
- Last sample accepted at edge t:
  - ARM during cycle t+1.
  - If `DSO`=0, first `DSI`=1 cycle is t+2.
  - Last `DSI`=1 cycle is t+1+`N_SAMPLES`.
- `DSO` sampled high at edge d → `res_valid`=1 and `res_data`=`DO`(d) from cycle d+1.
- `DSO` high during SEND is ignored; only WAIT captures.
- Minimum repetition period is `N_SAMPLES`+1+`N_SAMPLES`+core latency+2 cycles.

## Configuration
- Macro: `MEDIAN_DRIVER_TIMEOUT_EN`.
- **Defined**
  - A WAIT-state watchdog counts cycles since entering WAIT.
  - If it reaches `TIMEOUT` without `DSO`, go to LOAD and set `err`=1; `res_valid` stays 0.
  - `err` clears on the next successful `res_valid` handshake or on reset.
- **Undefined**
  - WAIT waits indefinitely; `err` is constant 0.
  - No watchdog logic.

## Structure
- Package `median_pkg`:
  - `sample_t` (8-bit logic).
  - FSM state enum `median_drv_state_t`.
  - Default constants `MEDIAN_N_SAMPLES`=9 and `MEDIAN_DRV_TIMEOUT`=64.
- Sub-module `median_drv_buf`: `N_SAMPLES`×8 register file with one write port (`wcnt`) and one read port (`rcnt`), no reset on storage. The FSM, counters and handshakes stay in `median_driver`.

## Test plan
- **Basic burst:** feed 9,3,7,1,5,8,2,6,4 with `in_valid` always 1.
  - `in_ready` drops after the 9th sample.
  - `DSI`=1 for exactly 9 consecutive cycles with `DI` in the same order.
  - Model `DSO`/`DO`=5 two cycles later → `res_valid`=1, `res_data`=5 the following cycle.
- **Bursty upstream and backpressure:** `in_valid` toggles randomly; `res_ready` held 0 for 20 cycles.
  - `DSI` burst still contiguous.
  - `res_data` stable, `res_valid` held, no new samples accepted until `res_ready`=1.
- **Level-held DSO:** model holds `DSO`=1 after the first result.
  - Second burst stalls in ARM (`DSI`=0) until `DSO`=0.
  - Exactly one result per burst.
- **Reset mid-SEND:** assert `nRST`=0 at the 4th `DSI` cycle.
  - Next cycle `DSI`=0, `DI`=0, `in_ready`=1 after release.
  - A fresh 9-sample burst then produces the correct median.
- **Timeout (macro defined, `TIMEOUT`=16):** model never raises `DSO`.
  - 16 cycles after WAIT entry, `err`=1 and `in_ready`=1.
  - A following good transaction clears `err` on its result handshake.
- **Macro undefined, same stimulus:** `err` stays 0 and the block remains in WAIT; `in_ready`=0 indefinitely.
